// File: rtl/prim_fifoq.sv
// prim_fifoq: parametrised first-word-fall-through FIFO with valid/ready on
// both sides, occupancy/almost flags, synchronous flush and a head+1 peek.
module prim_fifoq #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_LEVEL  = DEPTH - 1,
  parameter int unsigned AEMPTY_LEVEL = 1,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  output logic             urdy_o,
  input  logic             uvld_i,
  input  logic [WIDTH-1:0] udat_i,
  input  logic             drdy_i,
  output logic             dvld_o,
  output logic [WIDTH-1:0] ddat_o,
  output logic             inner_vld_o,
  output logic [WIDTH-1:0] inner_dat_o,
  output logic [CW-1:0]    count_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
);

  // Pointer width; DEPTH need not be a power of two, so wrap is an explicit compare.
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rp_q, rp_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_inner;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty;
  logic             up_beat, dn_beat;

  // Advance a pointer by one, wrapping from DEPTH-1 back to 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode; both readies/valids come from registered count only.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    up_beat = uvld_i & ~full;
    dn_beat = drdy_i & ~empty;
  end

  assign urdy_o = ~full;
  assign dvld_o = ~empty;

  // Next-state for pointers and occupancy; flush overrides any beat.
  always_comb begin
    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;
    if (flush_i) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      if (up_beat) wp_d = ptr_inc(wp_q);
      if (dn_beat) rp_d = ptr_inc(rp_q);
      unique case ({up_beat, dn_beat})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset drops all entries immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (up_beat && !flush_i) mem_q[wp_q] <= udat_i;
  end

  assign rp_inner = ptr_inc(rp_q);

  // Read-side decode of head and second entry, zeroed when not present.
  always_comb begin
    inner_vld_o = (count_q >= CW'(2));
    ddat_o      = dvld_o      ? mem_q[rp_q]     : '0;
    inner_dat_o = inner_vld_o ? mem_q[rp_inner] : '0;
  end

  // Occupancy reporting.
  always_comb begin
    count_o        = count_q;
    almost_full_o  = (32'(count_q) >= AFULL_LEVEL);
    almost_empty_o = (32'(count_q) <= AEMPTY_LEVEL);
  end

endmodule

// File: tb/tb_prim_fifoq.sv
// Bench for prim_fifoq: queue scoreboard per instance plus directed checks.
module tb_prim_fifoq;

  logic clk;
  logic reset_n;

  // Instance A: DEPTH=4
  logic        a_flush, a_urdy, a_uvld, a_drdy, a_dvld, a_ivld, a_afull, a_aempty;
  logic [31:0] a_udat, a_ddat, a_idat;
  logic [2:0]  a_count;

  // Instance B: DEPTH=3
  logic        b_flush, b_urdy, b_uvld, b_drdy, b_dvld, b_ivld, b_afull, b_aempty;
  logic [31:0] b_udat, b_ddat, b_idat;
  logic [1:0]  b_count;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  prim_fifoq #(.WIDTH(32), .DEPTH(4)) u_a (
    .clk(clk), .reset_n(reset_n), .flush_i(a_flush),
    .urdy_o(a_urdy), .uvld_i(a_uvld), .udat_i(a_udat),
    .drdy_i(a_drdy), .dvld_o(a_dvld), .ddat_o(a_ddat),
    .inner_vld_o(a_ivld), .inner_dat_o(a_idat), .count_o(a_count),
    .almost_full_o(a_afull), .almost_empty_o(a_aempty)
  );

  prim_fifoq #(.WIDTH(32), .DEPTH(3)) u_b (
    .clk(clk), .reset_n(reset_n), .flush_i(b_flush),
    .urdy_o(b_urdy), .uvld_i(b_uvld), .udat_i(b_udat),
    .drdy_i(b_drdy), .dvld_o(b_dvld), .ddat_o(b_ddat),
    .inner_vld_o(b_ivld), .inner_dat_o(b_idat), .count_o(b_count),
    .almost_full_o(b_afull), .almost_empty_o(b_aempty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard step: compare DUT against queue model, then apply this cycle's beats.
  task automatic model_step(input int id, input int depth, input int afl,
                            input logic urdy, input logic dvld, input logic [31:0] ddat,
                            input logic ivld, input logic [31:0] idat, input int cnt,
                            input logic afull, input logic aempty,
                            input logic uvld, input logic [31:0] udat,
                            input logic drdy, input logic flush);
    logic [31:0] m[$];
    logic [31:0] e;
    logic [31:0] exp_d, exp_i;
    bit pop, push;
    string t;
    int sz;
    t = (id == 0) ? "A" : "B";
    if (id == 0) m = qa; else m = qb;
    sz    = m.size();
    exp_d = (sz >= 1) ? m[0] : 32'h0;
    exp_i = (sz >= 2) ? m[1] : 32'h0;
    check({t, "_count"},  32'(cnt),    32'(sz));
    check({t, "_urdy"},   32'(urdy),   32'(sz != depth));
    check({t, "_dvld"},   32'(dvld),   32'(sz != 0));
    check({t, "_ddat"},   ddat,        exp_d);
    check({t, "_ivld"},   32'(ivld),   32'(sz >= 2));
    check({t, "_idat"},   idat,        exp_i);
    check({t, "_afull"},  32'(afull),  32'(sz >= afl));
    check({t, "_aempty"}, 32'(aempty), 32'(sz <= 1));
    if (flush) begin
      m.delete();
    end else begin
      pop  = (sz != 0) && drdy;
      push = uvld && (sz != depth);
      if (pop) begin
        e = m.pop_front();
        check({t, "_pop"}, ddat, e);
      end
      if (push) m.push_back(udat);
    end
    if (id == 0) qa = m; else qb = m;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      qa.delete();
      qb.delete();
    end else begin
      model_step(0, 4, 3, a_urdy, a_dvld, a_ddat, a_ivld, a_idat, 32'(a_count),
                 a_afull, a_aempty, a_uvld, a_udat, a_drdy, a_flush);
      model_step(1, 3, 2, b_urdy, b_dvld, b_ddat, b_ivld, b_idat, 32'(b_count),
                 b_afull, b_aempty, b_uvld, b_udat, b_drdy, b_flush);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_flush = 1'b0; a_uvld = 1'b0; a_udat = '0; a_drdy = 1'b0;
    b_flush = 1'b0; b_uvld = 1'b0; b_udat = '0; b_drdy = 1'b0;
    repeat (3) cyc();

    // Reset values
    check("rst_count",  32'(a_count),  32'd0);
    check("rst_urdy",   32'(a_urdy),   32'd1);
    check("rst_dvld",   32'(a_dvld),   32'd0);
    check("rst_ddat",   a_ddat,        32'h0);
    check("rst_ivld",   32'(a_ivld),   32'd0);
    check("rst_idat",   a_idat,        32'h0);
    check("rst_afull",  32'(a_afull),  32'd0);
    check("rst_aempty", 32'(a_aempty), 32'd1);
    reset_n = 1'b1;
    cyc();

    // Fill A0..A3 with downstream stalled
    a_uvld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_udat = 32'hA0 + 32'(i);
      cyc();
    end
    a_uvld = 1'b0;
    check("fill_count", 32'(a_count), 32'd4);
    check("fill_urdy",  32'(a_urdy),  32'd0);
    check("fill_afull", 32'(a_afull), 32'd1);
    check("fill_ddat",  a_ddat,       32'hA0);
    check("fill_idat",  a_idat,       32'hA1);

    // Full: push 0xFF and pop together; push must be refused
    a_uvld = 1'b1; a_udat = 32'hFF; a_drdy = 1'b1;
    cyc();
    a_uvld = 1'b0; a_drdy = 1'b0;
    check("fullpp_count", 32'(a_count), 32'd3);
    check("fullpp_ddat",  a_ddat,       32'hA1);
    check("fullpp_urdy",  32'(a_urdy),  32'd1);
    a_uvld = 1'b1; a_udat = 32'hB0;
    cyc();
    a_uvld = 1'b0;
    check("fullpp_next_count", 32'(a_count), 32'd4);

    // Drain: expect A1,A2,A3,B0 via scoreboard
    a_drdy = 1'b1;
    repeat (4) cyc();
    a_drdy = 1'b0;
    check("drain_count", 32'(a_count), 32'd0);

    // Single entry with simultaneous push and pop
    a_uvld = 1'b1; a_udat = 32'h11;
    cyc();
    a_udat = 32'h22; a_drdy = 1'b1;
    cyc();
    a_uvld = 1'b0; a_drdy = 1'b0;
    check("one_count", 32'(a_count), 32'd1);
    check("one_ddat",  a_ddat,       32'h22);
    check("one_ivld",  32'(a_ivld),  32'd0);
    a_drdy = 1'b1;
    cyc();
    a_drdy = 1'b0;

    // Flush priority over push and pop
    a_uvld = 1'b1; a_udat = 32'h33;
    cyc();
    a_udat = 32'h44;
    cyc();
    check("pre_flush_count", 32'(a_count), 32'd2);
    a_flush = 1'b1; a_udat = 32'h55; a_drdy = 1'b1;
    cyc();
    a_flush = 1'b0; a_uvld = 1'b0; a_drdy = 1'b0;
    check("flush_count",  32'(a_count),  32'd0);
    check("flush_dvld",   32'(a_dvld),   32'd0);
    check("flush_ddat",   a_ddat,        32'h0);
    check("flush_aempty", 32'(a_aempty), 32'd1);
    check("flush_urdy",   32'(a_urdy),   32'd1);

    // Asynchronous reset mid-cycle with three entries
    a_uvld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_udat = 32'hC0 + 32'(i);
      cyc();
    end
    a_uvld = 1'b0;
    check("pre_arst_count", 32'(a_count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count",  32'(a_count),  32'd0);
    check("arst_dvld",   32'(a_dvld),   32'd0);
    check("arst_ddat",   a_ddat,        32'h0);
    check("arst_urdy",   32'(a_urdy),   32'd1);
    check("arst_ivld",   32'(a_ivld),   32'd0);
    check("arst_aempty", 32'(a_aempty), 32'd1);
    cyc();
    reset_n = 1'b1;
    a_uvld = 1'b1; a_udat = 32'hD0;
    cyc();
    a_uvld = 1'b0;
    check("post_arst_dvld",  32'(a_dvld),  32'd1);
    check("post_arst_ddat",  a_ddat,       32'hD0);
    check("post_arst_count", 32'(a_count), 32'd1);
    a_drdy = 1'b1;
    cyc();
    a_drdy = 1'b0;

    // Streaming through DEPTH=3 across several pointer wraps
    b_uvld = 1'b1; b_drdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_udat = 32'd100 + 32'(i);
      cyc();
      if (i == 0) check("stream_first_count", 32'(b_count), 32'd1);
    end
    b_uvld = 1'b0; b_drdy = 1'b0;
    check("stream_count", 32'(b_count), 32'd1);
    check("stream_ddat",  b_ddat,       32'd119);
    b_drdy = 1'b1;
    cyc();
    b_drdy = 1'b0;
    check("stream_empty", 32'(b_dvld), 32'd0);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
